pipe_front_regs: RTL



---
 rtl/pipe_front_regs_if.sv | 41 ++++
 rtl/pipe_front_regs.sv | 88 ++++++++
 2 files changed

// File: rtl/pipe_front_regs_if.sv
// pipe_front_regs_if: control/data bundle between the hazard unit, fetch and the front-end register bank.
//   instr_in, redirect_target          : fetched word and branch/jump target
//   stall_flush_IR2, stall_flush_IR3   : per-stage stall/flush control words
//   PC_stall, PC2_stall                : hold fetch PC / hold PC2
//   pc_out, pc2, ir2, pc3, ir3         : fetch address and stage PC/instruction registers
//   valid2, valid3                     : stage holds a real (non-bubble) instruction
//   stall_cnt, flush_cnt               : saturating event counters
//   stall_timeout, protocol_err        : sticky debug flags
// master = control/fetch side, slave = register bank.
interface pipe_front_regs_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  instr_in;
    logic [XLEN-1:0]  redirect_target;
    logic [1:0]       stall_flush_IR2;
    logic             stall_flush_IR3;
    logic             PC_stall;
    logic             PC2_stall;
    logic [XLEN-1:0]  pc_out;
    logic [XLEN-1:0]  pc2;
    logic [XLEN-1:0]  ir2;
    logic [XLEN-1:0]  pc3;
    logic [XLEN-1:0]  ir3;
    logic             valid2;
    logic             valid3;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             stall_timeout;
    logic             protocol_err;

    modport master (
        output instr_in, redirect_target, stall_flush_IR2, stall_flush_IR3, PC_stall, PC2_stall,
        input  pc_out, pc2, ir2, pc3, ir3, valid2, valid3, stall_cnt, flush_cnt, stall_timeout, protocol_err
    );

    modport slave (
        input  instr_in, redirect_target, stall_flush_IR2, stall_flush_IR3, PC_stall, PC2_stall,
        output pc_out, pc2, ir2, pc3, ir3, valid2, valid3, stall_cnt, flush_cnt, stall_timeout, protocol_err
    );
endinterface

// File: rtl/pipe_front_regs.sv
// pipe_front_regs: fetch PC, IF/ID and ID/EX registers driven by the stall/flush control word.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : pipe_front_regs_if.slave (controls in; PC/IR stages, counters and flags out)
module pipe_front_regs #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_WORD  = '0,
    parameter int              PC_INC    = 4,
    parameter int              CNT_W     = 16,
    parameter int              MAX_STALL = 8
) (
    input logic              clk,
    input logic              rst_n,
    pipe_front_regs_if.slave bus
);
    localparam int RUN_W = $clog2(MAX_STALL + 1);

    logic [XLEN-1:0]  pc_q, pc_d, pc2_q, pc2_d, ir2_q, ir2_d, pc3_q, pc3_d, ir3_q, ir3_d;
    logic             v2_q, v2_d, v3_q, v3_d, tmo_q, tmo_d, perr_q, perr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             adv, flush, hold, stall;

    always_comb begin
        adv         = bus.stall_flush_IR2 == 2'b00;
        flush       = bus.stall_flush_IR2 == 2'b01;
        stall       = bus.stall_flush_IR2 == 2'b10;
        // the illegal code 11 behaves as a hold for the stage and the watchdog
        hold        = bus.stall_flush_IR2[1];
        pc_d        = flush ? bus.redirect_target : bus.PC_stall ? pc_q : pc_q + XLEN'(PC_INC);
        ir2_d       = flush ? NOP_WORD : adv ? bus.instr_in : ir2_q;
        v2_d        = flush ? 1'b0 : adv ? 1'b1 : v2_q;
        pc2_d       = flush ? '0 : (adv && !bus.PC2_stall) ? pc_q : pc2_q;
        // ID/EX always sees pre-edge IF/ID contents
        ir3_d       = bus.stall_flush_IR3 ? NOP_WORD : ir2_q;
        pc3_d       = bus.stall_flush_IR3 ? '0 : pc2_q;
        v3_d        = bus.stall_flush_IR3 ? 1'b0 : v2_q;
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
        run_d       = !hold ? '0 : (run_q == RUN_W'(MAX_STALL)) ? run_q : run_q + RUN_W'(1);
        // trips on the same edge that completes the MAX_STALL-th hold
        tmo_d       = tmo_q | (run_d == RUN_W'(MAX_STALL));
        perr_d      = perr_q | (bus.stall_flush_IR2 == 2'b11) | (adv & bus.PC_stall) | (stall & !bus.PC_stall);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            pc2_q       <= '0;
            ir2_q       <= NOP_WORD;
            v2_q        <= 1'b0;
            pc3_q       <= '0;
            ir3_q       <= NOP_WORD;
            v3_q        <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            run_q       <= '0;
            tmo_q       <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pc2_q       <= pc2_d;
            ir2_q       <= ir2_d;
            v2_q        <= v2_d;
            pc3_q       <= pc3_d;
            ir3_q       <= ir3_d;
            v3_q        <= v3_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            run_q       <= run_d;
            tmo_q       <= tmo_d;
            perr_q      <= perr_d;
        end
    end

    assign bus.pc_out        = pc_q;
    assign bus.pc2           = pc2_q;
    assign bus.ir2           = ir2_q;
    assign bus.valid2        = v2_q;
    assign bus.pc3           = pc3_q;
    assign bus.ir3           = ir3_q;
    assign bus.valid3        = v3_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;
    assign bus.stall_timeout = tmo_q;
    assign bus.protocol_err  = perr_q;
endmodule
